// File: rtl/tx_fifo_wr_arbiter.sv
// tx_fifo_wr_arbiter
//   Shares the single TX FIFO write port between NUM_REQ response sources. A round-robin
//   arbiter grants one requester at a time. Each grant is a 1- or 2-byte atomic burst, sent
//   LSB first, so bytes from different requesters are never interleaved.
//
// Ports
//   CLK          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   REQ_VLD      per-requester request valid, held until REQ_RDY
//   REQ_DATA     payload, requester i at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   REQ_2BYTE    1: send LSB then MSB, 0: LSB only
//   REQ_RDY      one-hot combinational accept pulse
//   FIFO_FULL    TX FIFO full flag
//   FIFO_P_DATA  byte to FIFO, zero when no strobe
//   FIFO_WR_INC  FIFO write strobe
//   BUSY         high while a burst is buffered / in flight
//   GRANT_ID     index of current / last granted requester
//   BYTE_CNT     saturating count of bytes written since reset
module tx_fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                REQ_VLD,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0]   REQ_DATA,
  input  logic [NUM_REQ-1:0]                REQ_2BYTE,
  output logic [NUM_REQ-1:0]                REQ_RDY,
  input  logic                              FIFO_FULL,
  output logic [DATA_WIDTH-1:0]             FIFO_P_DATA,
  output logic                              FIFO_WR_INC,
  output logic                              BUSY,
  output logic [$clog2(NUM_REQ)-1:0]        GRANT_ID,
  output logic [CNT_WIDTH-1:0]              BYTE_CNT
);

  localparam int unsigned GidW = $clog2(NUM_REQ);
  localparam int unsigned PayW = 2 * DATA_WIDTH;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSendLo = 2'd1;
  localparam logic [1:0] StSendHi = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [GidW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PayW-1:0]      buf_q, buf_d;
  logic                 buf_2byte_q, buf_2byte_d;
  logic [GidW-1:0]      grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic [PayW-1:0] req_data_arr [NUM_REQ];
  logic            any_req;
  logic [GidW-1:0] grant_idx;
  logic            wr_inc;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_arr[g] = REQ_DATA[g*PayW +: PayW];
  end

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    logic [GidW-1:0] idx;
    idx       = '0;
    any_req   = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = GidW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!any_req && REQ_VLD[idx]) begin
        any_req   = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // A byte goes out in either send state whenever the FIFO has room.
  assign wr_inc = ((state_q == StSendLo) || (state_q == StSendHi)) && !FIFO_FULL;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    buf_d       = buf_q;
    buf_2byte_d = buf_2byte_q;
    grant_id_d  = grant_id_q;
    byte_cnt_d  = byte_cnt_q;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          buf_d       = req_data_arr[grant_idx];
          buf_2byte_d = REQ_2BYTE[grant_idx];
          grant_id_d  = grant_idx;
          rr_ptr_d    = (grant_idx == GidW'(NUM_REQ - 1)) ? '0 : grant_idx + GidW'(1);
          state_d     = StSendLo;
        end
      end
      StSendLo: begin
        if (!FIFO_FULL) state_d = buf_2byte_q ? StSendHi : StIdle;
      end
      StSendHi: begin
        if (!FIFO_FULL) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (wr_inc && (byte_cnt_q != '1)) byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      buf_q       <= '0;
      buf_2byte_q <= 1'b0;
      grant_id_q  <= '0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      buf_q       <= buf_d;
      buf_2byte_q <= buf_2byte_d;
      grant_id_q  <= grant_id_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  // Combinational outputs are forced quiet while rst is high so a reset landing mid-burst
  // suppresses the pending byte and no grant is offered during reset.
  always_comb begin
    REQ_RDY     = '0;
    FIFO_WR_INC = 1'b0;
    FIFO_P_DATA = '0;
    BUSY        = 1'b0;
    if (!rst) begin
      if ((state_q == StIdle) && any_req) REQ_RDY[grant_idx] = 1'b1;
      FIFO_WR_INC = wr_inc;
      if (wr_inc) begin
        FIFO_P_DATA = (state_q == StSendHi) ? buf_q[PayW-1:DATA_WIDTH] : buf_q[DATA_WIDTH-1:0];
      end
      BUSY = (state_q != StIdle);
    end
  end

  assign GRANT_ID = grant_id_q;
  assign BYTE_CNT = byte_cnt_q;

endmodule

// File: tb/tb_tx_fifo_wr_arbiter.sv
// Testbench for tx_fifo_wr_arbiter (DATA_WIDTH=8, NUM_REQ=2, CNT_WIDTH=4).
// Expected bytes are queued when a grant is seen and checked by a monitor on each strobe.
module tb_tx_fifo_wr_arbiter;

  localparam int unsigned DW     = 8;
  localparam int unsigned NR     = 2;
  localparam int unsigned CW     = 4;
  localparam int unsigned CntMax = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vld;
  logic [NR*2*DW-1:0] req_data;
  logic [NR-1:0]   req_2byte;
  logic [NR-1:0]   req_rdy;
  logic            fifo_full;
  logic [DW-1:0]   fifo_p_data;
  logic            fifo_wr_inc;
  logic            busy;
  logic [0:0]      grant_id;
  logic [CW-1:0]   byte_cnt;

  always #5 clk = ~clk;

  tx_fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK        (clk),
    .rst        (rst),
    .REQ_VLD    (req_vld),
    .REQ_DATA   (req_data),
    .REQ_2BYTE  (req_2byte),
    .REQ_RDY    (req_rdy),
    .FIFO_FULL  (fifo_full),
    .FIFO_P_DATA(fifo_p_data),
    .FIFO_WR_INC(fifo_wr_inc),
    .BUSY       (busy),
    .GRANT_ID   (grant_id),
    .BYTE_CNT   (byte_cnt)
  );

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        t0;
    logic        t1;
    int unsigned grant;
  } vec_t;

  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  int unsigned exp_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    if (exp_cnt < CntMax) exp_cnt++;
  endtask

  // Every strobe must match the head of the expected queue; idle cycles must drive zero.
  always @(negedge clk) begin
    if (fifo_wr_inc) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got 0x%0h, expected no write", fifo_p_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("fifo_byte", 32'(fifo_p_data), 32'(mon_exp));
      end
    end else begin
      check("idle_data_zero", 32'(fifo_p_data), 32'h0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after one reset cycle.
  task automatic pulse_reset();
    rst     = 1'b1;
    req_vld = '0;
    @(posedge clk); #1;
    rst     = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check({name, "_drain"}, 32'(done), 32'h1);
    check({name, "_cnt"}, 32'(byte_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
  endtask

  task automatic do_req(input vec_t v, input string name);
    bit          seen = 1'b0;
    logic [15:0] d;
    logic        two;
    req_vld   = v.vld;
    req_data  = {v.d1, v.d0};
    req_2byte = {v.t1, v.t0};
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (req_rdy != '0) begin
        seen = 1'b1;
        check({name, "_rdy"}, 32'(req_rdy), 32'h1 << v.grant);
        d   = (v.grant == 1) ? v.d1 : v.d0;
        two = (v.grant == 1) ? v.t1 : v.t0;
        push_byte(d[7:0]);
        if (two) push_byte(d[15:8]);
      end
      @(posedge clk); #1;
    end
    req_vld = '0;
    check({name, "_granted"}, 32'(seen), 32'h1);
    @(negedge clk);
    check({name, "_gid"}, 32'(grant_id), 32'(v.grant));
    wait_drain(name);
  endtask

  vec_t vecs [6];
  int   con_rdy [10] = '{1, 0, 2, 0, 0, 1, 0, 2, 0, 0};
  int   con_gid [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};

  initial begin
    vecs[0] = '{vld: 2'b10, d0: 16'h0000, d1: 16'hA55A, t0: 1'b0, t1: 1'b1, grant: 1};
    vecs[1] = '{vld: 2'b01, d0: 16'h1234, d1: 16'h0000, t0: 1'b0, t1: 1'b0, grant: 0};
    vecs[2] = '{vld: 2'b11, d0: 16'h00C3, d1: 16'hBBAA, t0: 1'b0, t1: 1'b1, grant: 1};
    vecs[3] = '{vld: 2'b11, d0: 16'h5566, d1: 16'h00DD, t0: 1'b1, t1: 1'b0, grant: 0};
    vecs[4] = '{vld: 2'b01, d0: 16'h0077, d1: 16'h0000, t0: 1'b0, t1: 1'b0, grant: 0};
    vecs[5] = '{vld: 2'b10, d0: 16'h0000, d1: 16'hFF01, t0: 1'b0, t1: 1'b0, grant: 1};

    rst       = 1'b1;
    req_vld   = 2'b11;
    req_data  = '0;
    req_2byte = '0;
    fifo_full = 1'b0;
    exp_cnt   = 0;

    // Reset held two cycles with both requests pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_rdy", 32'(req_rdy), 32'h0);
      check("rst_wr", 32'(fifo_wr_inc), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      if (i == 1) begin
        check("rst_cnt", 32'(byte_cnt), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);
      end
      @(posedge clk); #1;
    end
    rst     = 1'b0;
    req_vld = '0;

    // Single bursts from the table; rr_ptr evolves across rows.
    for (int i = 0; i < 6; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Contention: both requests held from a fresh reset.
    pulse_reset();
    req_data  = {16'h2233, 16'h0011};
    req_2byte = 2'b10;
    req_vld   = 2'b11;
    push_byte(8'h11); push_byte(8'h33); push_byte(8'h22);
    push_byte(8'h11); push_byte(8'h33); push_byte(8'h22);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("con_rdy_c%0d", c), 32'(req_rdy), 32'(con_rdy[c]));
      check($sformatf("con_gid_c%0d", c), 32'(grant_id), 32'(con_gid[c]));
      @(posedge clk); #1;
      if (c == 9) req_vld = '0;
    end
    wait_drain("con");

    // Backpressure during the MSB of 16'hBEEF.
    req_vld   = 2'b01;
    req_data  = {16'h0000, 16'hBEEF};
    req_2byte = 2'b01;
    @(negedge clk);
    check("bp_rdy", 32'(req_rdy), 32'h1);
    push_byte(8'hEF); push_byte(8'hBE);
    @(posedge clk); #1;
    req_vld = '0;
    @(negedge clk);
    check("bp_lo_wr", 32'(fifo_wr_inc), 32'h1);
    @(posedge clk); #1;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_wr", 32'(fifo_wr_inc), 32'h0);
      check("bp_stall_busy", 32'(busy), 32'h1);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check("bp_hi_wr", 32'(fifo_wr_inc), 32'h1);
    @(posedge clk); #1;
    wait_drain("bp");

    // Reset during SEND_HI: MSB dropped, rr_ptr back to 0 so requester 0 wins again.
    req_vld   = 2'b01;
    req_data  = {16'h0099, 16'h6655};
    req_2byte = 2'b01;
    @(negedge clk);
    check("mr_rdy", 32'(req_rdy), 32'h1);
    push_byte(8'h55);
    @(posedge clk); #1;
    req_vld   = 2'b11;
    req_data  = {16'h0099, 16'h0044};
    req_2byte = 2'b00;
    @(negedge clk);
    check("mr_lo_wr", 32'(fifo_wr_inc), 32'h1);
    check("mr_lo_rdy", 32'(req_rdy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_wr", 32'(fifo_wr_inc), 32'h0);
    check("mr_rst_busy", 32'(busy), 32'h0);
    check("mr_rst_rdy", 32'(req_rdy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    check("mr_idle_busy", 32'(busy), 32'h0);
    check("mr_regrant_rdy", 32'(req_rdy), 32'h1);
    check("mr_cnt_cleared", 32'(byte_cnt), 32'h0);
    push_byte(8'h44);
    @(posedge clk); #1;
    req_vld = '0;
    wait_drain("mr");

    // Saturation: 20 single bytes into a 4-bit counter.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v = '{vld: 2'b01, d0: 16'h00A0 + 16'(i), d1: 16'h0000, t0: 1'b0, t1: 1'b0, grant: 0};
      do_req(v, $sformatf("sat%0d", i));
    end
    check("sat_final", 32'(byte_cnt), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
